run_controller: RTL

- Responder end of the top-level Start/Ack launch handshake. Sits inside TopLevel between the external Start/Ack pins and the program counter and datapath enables.
- On each Start pulse it loads the next program's base address into the PC. It runs the core until the decoder flags a halt, then raises Ack.
- Also captures per-program diagnostics: cycle count, last PC, and a timeout flag.

---
 rtl/run_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// run_controller: responder side of the Start/Ack launch handshake.
// Sequences IDLE -> ARMED -> LAUNCH -> RUN -> DONE. It loads the selected
// program's base address into the PC, gates the core while the program runs,
// and captures diagnostics: cycle count, final PC and a watchdog flag.
module run_controller #(
   parameter int unsigned PC_W       = 10,
   parameter int unsigned CYC_W      = 16,
   parameter int unsigned P1_BASE    = 0,
   parameter int unsigned P2_BASE    = 256,
   parameter int unsigned P3_BASE    = 512,
   parameter int unsigned MAX_CYCLES = 65000
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Halt,
   input  logic [PC_W-1:0]  ProgCtr,
   output logic             PcLoad,
   output logic [PC_W-1:0]  PcLoadAddr,
   output logic             CpuEn,
   output logic             Ack,
   output logic [1:0]       ProgSel,
   output logic [CYC_W-1:0] CycleCount,
   output logic [PC_W-1:0]  LastPc,
   output logic             Timeout
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARMED  = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]       r_state;
   logic             r_pc_load;
   logic             r_cpu_en;
   logic             r_ack;
   logic [1:0]       r_prog_sel;
   logic [CYC_W-1:0] r_cycle_count;
   logic [PC_W-1:0]  r_last_pc;
   logic             r_timeout;

   logic             w_wd_fire;
   logic [1:0]       w_sel_next;

   // The watchdog fires in the cycle whose count (before increment) is
   // MAX_CYCLES-1, so the finished count reads exactly MAX_CYCLES.
   assign w_wd_fire  = (r_cycle_count == CYC_W'(MAX_CYCLES - 1)) && !Halt;
   // Program index rotates 0 -> 1 -> 2 -> 0; the unused code 3 also returns to 0.
   assign w_sel_next = (r_prog_sel >= 2'd2) ? 2'd0 : r_prog_sel + 2'd1;

   // Base address of the selected program; only output that is not registered.
   always_comb begin
      PcLoadAddr = PC_W'(P1_BASE);
      case (r_prog_sel)
         2'd1:    PcLoadAddr = PC_W'(P2_BASE);
         2'd2:    PcLoadAddr = PC_W'(P3_BASE);
         default: PcLoadAddr = PC_W'(P1_BASE);
      endcase
   end

   // Handshake state machine with registered strobes and diagnostic capture.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state       <= S_IDLE;
         r_pc_load     <= 1'b0;
         r_cpu_en      <= 1'b0;
         r_ack         <= 1'b0;
         r_prog_sel    <= 2'd0;
         r_cycle_count <= '0;
         r_last_pc     <= '0;
         r_timeout     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_state <= S_ARMED;
                  r_ack   <= 1'b0;
               end
            end
            S_ARMED: begin
               // Launch happens on the falling level of Start.
               if (!Start) begin
                  r_state       <= S_LAUNCH;
                  r_pc_load     <= 1'b1;
                  r_cycle_count <= '0;
                  r_timeout     <= 1'b0;
               end
            end
            S_LAUNCH: begin
               r_state   <= S_RUN;
               r_pc_load <= 1'b0;
               r_cpu_en  <= 1'b1;
            end
            S_RUN: begin
               // The finishing cycle is counted too; Start is ignored here.
               r_cycle_count <= r_cycle_count + 1'b1;
               if (Halt || w_wd_fire) begin
                  r_state    <= S_DONE;
                  r_cpu_en   <= 1'b0;
                  r_ack      <= 1'b1;
                  r_last_pc  <= ProgCtr;
                  r_timeout  <= !Halt;
                  r_prog_sel <= w_sel_next;
               end
            end
            S_DONE: begin
               // Ack drops as soon as the next request is seen.
               if (Start) begin
                  r_state <= S_ARMED;
                  r_ack   <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_pc_load <= 1'b0;
               r_cpu_en  <= 1'b0;
            end
         endcase
      end
   end

   assign PcLoad     = r_pc_load;
   assign CpuEn      = r_cpu_en;
   assign Ack        = r_ack;
   assign ProgSel    = r_prog_sel;
   assign CycleCount = r_cycle_count;
   assign LastPc     = r_last_pc;
   assign Timeout    = r_timeout;

endmodule
